alu_writeback_buffer: RTL and testbench
=======================================

ALU_WRITEBACK_BUFFER -- requirements
Module: alu_writeback_buffer

Interface
REQ-001 Parameter DATABITWIDTH, default 16, SHALL set the width of result data.
REQ-002 Parameter REGADDRBITWIDTH, default 4, SHALL set the width of the destination register index.
REQ-003 Parameter DEPTH, default 4, power of two >= 2, SHALL set the number of queue entries.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 clear_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 ALUResultValid  in  1  SHALL indicate a result offered by the ALU stage.
REQ-007 ALUResultReady  out  1  SHALL indicate the buffer can accept the offered result.
REQ-008 ALUResultData  in  DATABITWIDTH  SHALL carry the ALU ResultOut value.
REQ-009 ALUResultDest  in  REGADDRBITWIDTH  SHALL carry the destination register index.
REQ-010 RegWriteEn  out  1  SHALL request the register-file write port.
REQ-011 RegWriteGrant  in  1  SHALL indicate the write port is granted this cycle.
REQ-012 RegWriteAddr  out  REGADDRBITWIDTH  SHALL carry the head entry's destination.
REQ-013 RegWriteData  out  DATABITWIDTH  SHALL carry the head entry's data.
REQ-014 PendingQueryAddr  in  REGADDRBITWIDTH  SHALL carry the register index for the hazard query.
REQ-015 PendingHit  out  1  SHALL flag that a stored entry targets PendingQueryAddr.
REQ-016 PendingData  out  DATABITWIDTH  SHALL carry the youngest matching entry's data.
REQ-017 Occupancy  out  clog2(DEPTH)+1  SHALL report the number of stored entries.

Function
REQ-018 Accept SHALL occur when ALUResultValid and ALUResultReady are both high on a rising edge.
REQ-019 ALUResultReady SHALL equal (Occupancy != DEPTH); it SHALL NOT depend on RegWriteGrant or ALUResultValid.
REQ-020 An accepted result with ALUResultDest == 0 SHALL be discarded (register 0 is hardwired zero) and SHALL NOT change Occupancy.
REQ-021 An accepted result with nonzero dest SHALL be written at the tail; it SHALL first appear on RegWriteEn one cycle after acceptance (minimum latency 1, no same-cycle bypass).
REQ-022 RegWriteEn SHALL equal (Occupancy != 0); RegWriteAddr/RegWriteData SHALL reflect the head entry and SHALL remain stable while RegWriteEn is high and RegWriteGrant is low.
REQ-023 Pop SHALL occur when RegWriteEn and RegWriteGrant are both high; entries SHALL retire in strict acceptance order.
REQ-024 Simultaneous push and pop SHALL leave Occupancy unchanged; push with nonzero dest and no pop SHALL increment it; pop with no push SHALL decrement it.
REQ-025 Head and tail pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by Occupancy, not pointer equality.
REQ-026 RegWriteGrant while RegWriteEn is low SHALL be ignored.
REQ-027 PendingHit SHALL be combinational: high iff any stored entry's dest equals PendingQueryAddr; it SHALL be low when PendingQueryAddr == 0.
REQ-028 PendingData SHALL be the data of the youngest (most recently accepted) matching stored entry; it SHALL be 0 when PendingHit is low.
REQ-029 The entry being popped in the current cycle SHALL still count for PendingHit in that cycle; the entry being accepted in the current cycle SHALL NOT.

Reset
REQ-030 clear_n low SHALL immediately set head, tail and Occupancy to 0, forcing RegWriteEn=0, PendingHit=0, PendingData=0, ALUResultReady=1.
REQ-031 Reset mid-operation SHALL discard all stored entries; entry storage SHALL NOT be reset.
REQ-032 The first accept SHALL be possible on the first rising edge after clear_n deasserts.

Structure
REQ-033 A shared package SHALL hold DATABITWIDTH/REGADDRBITWIDTH defaults and the writeback entry struct (data, dest).
REQ-034 The block SHALL be a single module with no sub-modules; the youngest-match search SHALL be an inline priority loop ordered from tail-1 back to head.

Verification
REQ-035 Push dest=3 data=0x1234, grant held high -> RegWriteEn high next cycle, Addr=3, Data=0x1234, Occupancy back to 0 one cycle later.
REQ-036 Grant low, push 4 results -> Ready low at Occupancy=4, 5th Valid not accepted; raise grant -> 4 writes in acceptance order, Ready high after first pop.
REQ-037 Push dest=0 data=0xFFFF -> no RegWriteEn, Occupancy stays 0; query addr 0 -> PendingHit=0.
REQ-038 Grant low, push (5,0x0001),(7,0x0002),(5,0x0003); query 5 -> PendingHit=1, PendingData=0x0003; query 6 -> PendingHit=0, PendingData=0.
REQ-039 Occupancy=2, simultaneous push and pop for 8 cycles -> Occupancy stays 2, pointers wrap, order preserved.
REQ-040 Occupancy=3, assert clear_n low between edges -> RegWriteEn and Occupancy 0 immediately; after release, a push retires normally.

Source files
------------

// File: rtl/alu_writeback_buffer_pkg.sv
// Shared widths and the writeback entry type for the ALU writeback buffer.
// Code that sees the buffer from outside, such as the bench model, uses these too.
package alu_writeback_buffer_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 16;
    localparam int DEFAULT_REG_ADDR_WIDTH = 4;

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0]     data;
        logic [DEFAULT_REG_ADDR_WIDTH-1:0] dest;
    } wb_entry_t;

endpackage

// File: rtl/alu_writeback_buffer.sv
// Buffers ALU results in order until the register-file write port is granted.
// A combinational lookup returns the youngest pending result for any register.
module alu_writeback_buffer
    import alu_writeback_buffer_pkg::*;
#(
    parameter int DATABITWIDTH    = DEFAULT_DATA_WIDTH,
    parameter int REGADDRBITWIDTH = DEFAULT_REG_ADDR_WIDTH,
    parameter int DEPTH           = 4
) (
    input  logic                        clk,
    input  logic                        clear_n,
    input  logic                        ALUResultValid,
    output logic                        ALUResultReady,
    input  logic [DATABITWIDTH-1:0]     ALUResultData,
    input  logic [REGADDRBITWIDTH-1:0]  ALUResultDest,
    output logic                        RegWriteEn,
    input  logic                        RegWriteGrant,
    output logic [REGADDRBITWIDTH-1:0]  RegWriteAddr,
    output logic [DATABITWIDTH-1:0]     RegWriteData,
    input  logic [REGADDRBITWIDTH-1:0]  PendingQueryAddr,
    output logic                        PendingHit,
    output logic [DATABITWIDTH-1:0]     PendingData,
    output logic [$clog2(DEPTH):0]      Occupancy
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int OCCW = PTRW + 1;

    typedef struct packed {
        logic [DATABITWIDTH-1:0]    data;
        logic [REGADDRBITWIDTH-1:0] dest;
    } entry_t;

    entry_t          storage [DEPTH];
    logic [PTRW-1:0] head;
    logic [PTRW-1:0] tail;
    logic [OCCW-1:0] count;
    logic            push;
    logic            pop;
    logic [PTRW-1:0] search_idx;

    assign ALUResultReady = (count != OCCW'(DEPTH));
    assign RegWriteEn     = (count != '0);
    assign Occupancy      = count;
    assign RegWriteAddr   = storage[head].dest;
    assign RegWriteData   = storage[head].data;

    // Writes to register 0 are dropped at the door; they still count as accepted.
    assign push = ALUResultValid && ALUResultReady && (ALUResultDest != '0);
    assign pop  = RegWriteEn && RegWriteGrant;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            storage[tail] <= '{data: ALUResultData, dest: ALUResultDest};
        end
    end

    // Walk from the youngest entry (tail-1) back towards head; the first match wins.
    always_comb begin
        PendingHit  = 1'b0;
        PendingData = '0;
        search_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            search_idx = tail - PTRW'(i + 1);
            if (!PendingHit && (OCCW'(i) < count) && (PendingQueryAddr != '0) &&
                (storage[search_idx].dest == PendingQueryAddr)) begin
                PendingHit  = 1'b1;
                PendingData = storage[search_idx].data;
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback_buffer.sv
// Self-checking bench for alu_writeback_buffer: directed scenarios plus random
// traffic, compared every cycle against a queue-based model of the buffer.
module tb_alu_writeback_buffer;
    import alu_writeback_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = DEFAULT_DATA_WIDTH;
    localparam int AW    = DEFAULT_REG_ADDR_WIDTH;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          clear_n;
    logic          alu_valid;
    logic          alu_ready;
    logic [DW-1:0] alu_data;
    logic [AW-1:0] alu_dest;
    logic          reg_write_en;
    logic          reg_write_grant;
    logic [AW-1:0] reg_write_addr;
    logic [DW-1:0] reg_write_data;
    logic [AW-1:0] query_addr;
    logic          pending_hit;
    logic [DW-1:0] pending_data;
    logic [OW-1:0] occupancy;

    wb_entry_t model_q[$];
    int        tests_run    = 0;
    int        tests_failed = 0;

    alu_writeback_buffer #(
        .DATABITWIDTH    (DW),
        .REGADDRBITWIDTH (AW),
        .DEPTH           (DEPTH)
    ) dut (
        .clk              (clk),
        .clear_n          (clear_n),
        .ALUResultValid   (alu_valid),
        .ALUResultReady   (alu_ready),
        .ALUResultData    (alu_data),
        .ALUResultDest    (alu_dest),
        .RegWriteEn       (reg_write_en),
        .RegWriteGrant    (reg_write_grant),
        .RegWriteAddr     (reg_write_addr),
        .RegWriteData     (reg_write_data),
        .PendingQueryAddr (query_addr),
        .PendingHit       (pending_hit),
        .PendingData      (pending_data),
        .Occupancy        (occupancy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Compare every output against what the model queue implies right now.
    task automatic checkAll();
        logic          exp_hit;
        logic [DW-1:0] exp_data;
        exp_hit  = 1'b0;
        exp_data = '0;
        for (int i = model_q.size() - 1; i >= 0; i--) begin
            if (!exp_hit && query_addr != '0 && model_q[i].dest == query_addr) begin
                exp_hit  = 1'b1;
                exp_data = model_q[i].data;
            end
        end
        checkOutput("occupancy", 32'(occupancy), 32'(model_q.size()));
        checkOutput("ready", 32'(alu_ready), 32'(model_q.size() != DEPTH));
        checkOutput("write_en", 32'(reg_write_en), 32'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            checkOutput("write_addr", 32'(reg_write_addr), 32'(model_q[0].dest));
            checkOutput("write_data", 32'(reg_write_data), 32'(model_q[0].data));
        end
        checkOutput("pending_hit", 32'(pending_hit), 32'(exp_hit));
        checkOutput("pending_data", 32'(pending_data), 32'(exp_data));
    endtask

    // Drive one cycle of inputs, check mid-cycle, then advance the model at the edge.
    task automatic applyStimulus(input logic valid, input logic [DW-1:0] data,
                                 input logic [AW-1:0] dest, input logic grant,
                                 input logic [AW-1:0] query);
        logic can_accept;
        logic do_pop;
        alu_valid       = valid;
        alu_data        = data;
        alu_dest        = dest;
        reg_write_grant = grant;
        query_addr      = query;
        @(negedge clk);
        checkAll();
        can_accept = (model_q.size() != DEPTH);
        do_pop     = (model_q.size() != 0) && grant;
        @(posedge clk);
        if (do_pop) begin
            void'(model_q.pop_front());
        end
        if (valid && can_accept && dest != '0) begin
            model_q.push_back('{data: data, dest: dest});
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, '0);
        end
    endtask

    initial begin
        clear_n         = 1'b0;
        alu_valid       = 1'b0;
        alu_data        = '0;
        alu_dest        = '0;
        reg_write_grant = 1'b0;
        query_addr      = '0;
        #12;
        checkAll();
        @(negedge clk);
        clear_n = 1'b1;
        @(posedge clk);
        #1;

        // Single result retires with grant held high.
        applyStimulus(1'b1, 16'h1234, 4'd3, 1'b1, 4'd3);
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd3);
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd3);

        // Fill to capacity, offer a fifth, then drain in order.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, DW'(16'hA000 + i), AW'(i + 1), 1'b0, AW'(i + 1));
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 4'd5);
        end

        // Register 0 results are discarded.
        applyStimulus(1'b1, 16'hFFFF, 4'd0, 1'b1, 4'd0);
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd0);

        // Youngest match wins for the hazard query.
        applyStimulus(1'b1, 16'h0001, 4'd5, 1'b0, 4'd5);
        applyStimulus(1'b1, 16'h0002, 4'd7, 1'b0, 4'd5);
        applyStimulus(1'b1, 16'h0003, 4'd5, 1'b0, 4'd5);
        applyStimulus(1'b0, '0, '0, 1'b0, 4'd5);
        applyStimulus(1'b0, '0, '0, 1'b0, 4'd6);
        applyStimulus(1'b0, '0, '0, 1'b0, 4'd7);
        drain();

        // Steady push and pop at occupancy 2 wraps the pointers.
        applyStimulus(1'b1, 16'h1111, 4'd1, 1'b0, 4'd1);
        applyStimulus(1'b1, 16'h2222, 4'd2, 1'b0, 4'd2);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, DW'(16'hB000 + i), AW'(i + 8), 1'b1, AW'(i + 7));
        end
        drain();

        // Asynchronous reset mid-cycle with three entries stored.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, DW'(16'hC000 + i), AW'(9 + i), 1'b0, 4'd9);
        end
        alu_valid       = 1'b0;
        reg_write_grant = 1'b0;
        query_addr      = 4'd9;
        #2;
        clear_n = 1'b0;
        #1;
        model_q.delete();
        checkAll();
        @(negedge clk);
        clear_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 16'h5A5A, 4'd6, 1'b0, 4'd6);
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd6);
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd6);

        // Random traffic with a small register range to provoke hazards and dest 0.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), DW'($urandom), AW'($urandom_range(0, 5)),
                          ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1, AW'($urandom_range(0, 5)));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
